// File: rtl/filter_window_ctrl.sv
// Sync edge detection, pixel/line counters and x/y window enables
// with frame-synchronous double-buffered window configuration.
module filter_window_ctrl #(
  parameter int    CNT_WIDTH = 12,
  parameter string HS_POL    = "POSITIVE",
  parameter string VS_POL    = "POSITIVE",
  parameter int    X_START   = 0,
  parameter int    X_END     = 640,
  parameter int    Y_START   = 0,
  parameter int    Y_END     = 720
) (
  input  logic                 i_pclk,
  input  logic                 i_arstn,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic                 i_cfg_wr,
  input  logic [1:0]           i_cfg_addr,
  input  logic [CNT_WIDTH-1:0] i_cfg_wdata,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_line_start,
  output logic                 o_frame_start,
  output logic                 o_x_en,
  output logic                 o_y_en,
  output logic                 o_win_en
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic HS_ACT = (HS_POL == "NEGATIVE") ? 1'b0 : 1'b1;
  localparam logic VS_ACT = (VS_POL == "NEGATIVE") ? 1'b0 : 1'b1;
  localparam cnt_t MAX    = '1;
  localparam cnt_t XS_RST = cnt_t'(X_START);
  localparam cnt_t XE_RST = cnt_t'(X_END);
  localparam cnt_t YS_RST = cnt_t'(Y_START);
  localparam cnt_t YE_RST = cnt_t'(Y_END);

  typedef enum logic [1:0] {
    L_IDLE, L_PRE, L_ACTIVE, L_POST
  } line_t;

  typedef enum logic {
    F_UNSYNC, F_SYNC
  } frame_t;

  logic   hs_q, vs_q;
  logic   hs_edge, vs_edge;
  cnt_t   x_cnt, y_cnt, x_nx, y_nx;
  cnt_t   stg_xs, stg_xe, stg_ys, stg_ye;
  cnt_t   xs, xe, ys, ye;
  cnt_t   xs_nx, xe_nx;
  line_t  line_st, line_nx;
  frame_t frame_st, frame_nx;

  assign hs_edge = (i_hsync == HS_ACT) && (hs_q != HS_ACT);
  assign vs_edge = (i_vsync == VS_ACT) && (vs_q != VS_ACT);

  assign o_hsync = hs_q;
  assign o_vsync = vs_q;

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      hs_q          <= ~HS_ACT;
      vs_q          <= ~VS_ACT;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      hs_q          <= i_hsync;
      vs_q          <= i_vsync;
      o_line_start  <= hs_edge;
      o_frame_start <= vs_edge;
    end
  end

  // Staging written any time; copied at the frame boundary
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      stg_xs <= XS_RST;
      stg_xe <= XE_RST;
      stg_ys <= YS_RST;
      stg_ye <= YE_RST;
    end else if (i_cfg_wr) begin
      unique case (i_cfg_addr)
        2'd0: stg_xs <= i_cfg_wdata;
        2'd1: stg_xe <= i_cfg_wdata;
        2'd2: stg_ys <= i_cfg_wdata;
        2'd3: stg_ye <= i_cfg_wdata;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      xs <= XS_RST;
      xe <= XE_RST;
      ys <= YS_RST;
      ye <= YE_RST;
    end else if (vs_edge) begin
      xs <= stg_xs;
      xe <= stg_xe;
      ys <= stg_ys;
      ye <= stg_ye;
    end
  end

  // Window bounds in force next cycle
  assign xs_nx = vs_edge ? stg_xs : xs;
  assign xe_nx = vs_edge ? stg_xe : xe;

  always_comb begin
    x_nx = '0;
    y_nx = y_cnt;
    if (!hs_edge)
      x_nx = (x_cnt == MAX) ? x_cnt : x_cnt + cnt_t'(1);
    if (vs_edge)
      y_nx = '0;
    else if (hs_edge && y_cnt != MAX)
      y_nx = y_cnt + cnt_t'(1);
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      line_st  <= L_IDLE;
      frame_st <= F_UNSYNC;
    end else begin
      x_cnt    <= x_nx;
      y_cnt    <= y_nx;
      line_st  <= line_nx;
      frame_st <= frame_nx;
    end
  end

  always_comb begin
    line_nx = line_st;
    o_x_en  = 1'b0;
    unique case (line_st)
      L_IDLE: ;
      L_PRE:
        if (x_nx == xs_nx)
          line_nx = (xs_nx < xe_nx) ? L_ACTIVE : L_POST;
      L_ACTIVE: begin
        o_x_en = 1'b1;
        if (x_nx == xe_nx)
          line_nx = L_POST;
      end
      L_POST: ;
    endcase
    if (hs_edge) begin
      if (xs_nx != '0)
        line_nx = L_PRE;
      else
        line_nx = (xe_nx != '0) ? L_ACTIVE : L_POST;
    end
  end

  always_comb begin
    frame_nx = frame_st;
    o_y_en   = 1'b0;
    if (vs_edge)
      frame_nx = F_SYNC;
    if (frame_st == F_SYNC)
      o_y_en = (y_cnt >= ys) && (y_cnt < ye);
  end

  assign o_win_en = o_x_en & o_y_en;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Scoreboard bench: positive and negative polarity instances
// driven by one stimulus stream and checked against a line/frame model.
module tb_filter_window_ctrl;

  localparam int LEN = 700;
  localparam int NW  = -10;
  localparam int NR  = -1;
  localparam int MX  = 4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hs = 1'b0, vs = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [11:0] wdata = '0;

  logic p_hsync, p_vsync, p_ls, p_fs, p_x_en, p_y_en, p_win_en;
  logic n_hsync, n_vsync, n_ls, n_fs, n_x_en, n_y_en, n_win_en;

  int checks = 0;
  int errors = 0;

  logic [6:0] q[$];

  int m_x, m_y, m_xs, m_xe, m_ys, m_ye, s_xs, s_xe, s_ys, s_ye;
  logic m_hp, m_vp, m_line, m_sync;

  int lx_cnt, lx_first, ly_cnt, lw_cnt;

  always #5 clk = ~clk;

  filter_window_ctrl dut_p (
    .i_pclk        (clk),
    .i_arstn       (rst_n),
    .i_hsync       (hs),
    .i_vsync       (vs),
    .i_cfg_wr      (wr),
    .i_cfg_addr    (addr),
    .i_cfg_wdata   (wdata),
    .o_hsync       (p_hsync),
    .o_vsync       (p_vsync),
    .o_line_start  (p_ls),
    .o_frame_start (p_fs),
    .o_x_en        (p_x_en),
    .o_y_en        (p_y_en),
    .o_win_en      (p_win_en)
  );

  filter_window_ctrl #(
    .HS_POL ("NEGATIVE"),
    .VS_POL ("NEGATIVE")
  ) dut_n (
    .i_pclk        (clk),
    .i_arstn       (rst_n),
    .i_hsync       (~hs),
    .i_vsync       (~vs),
    .i_cfg_wr      (wr),
    .i_cfg_addr    (addr),
    .i_cfg_wdata   (wdata),
    .o_hsync       (n_hsync),
    .o_vsync       (n_vsync),
    .o_line_start  (n_ls),
    .o_frame_start (n_fs),
    .o_x_en        (n_x_en),
    .o_y_en        (n_y_en),
    .o_win_en      (n_win_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hp = 1'b0; m_vp = 1'b0;
    m_x = 0; m_y = 0;
    m_line = 1'b0; m_sync = 1'b0;
    m_xs = 0; m_xe = 640; m_ys = 0; m_ye = 720;
    s_xs = 0; s_xe = 640; s_ys = 0; s_ye = 720;
  endtask

  // One rising edge of the reference behaviour
  task automatic model(input logic h, input logic v, input logic w,
                       input logic [1:0] a, input logic [11:0] d);
    logic he, ve, xen, yen;
    he = h & ~m_hp;
    ve = v & ~m_vp;
    if (ve) begin
      m_xs = s_xs; m_xe = s_xe; m_ys = s_ys; m_ye = s_ye;
    end
    if (w) begin
      if (a == 2'd0) s_xs = int'(d);
      if (a == 2'd1) s_xe = int'(d);
      if (a == 2'd2) s_ys = int'(d);
      if (a == 2'd3) s_ye = int'(d);
    end
    if (he) m_x = 0;
    else if (m_x < MX) m_x++;
    if (ve) m_y = 0;
    else if (he && m_y < MX) m_y++;
    if (he) m_line = 1'b1;
    if (ve) m_sync = 1'b1;
    m_hp = h;
    m_vp = v;
    xen = m_line && m_x >= m_xs && m_x < m_xe;
    yen = m_sync && m_y >= m_ys && m_y < m_ye;
    q.push_back({h, v, he, ve, xen, yen, xen & yen});
  endtask

  task automatic step(input logic h, input logic v, input logic w,
                      input logic [1:0] a, input logic [11:0] d);
    logic [6:0] e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pos_outs",
          {p_hsync, p_vsync, p_ls, p_fs, p_x_en, p_y_en, p_win_en}, e);
      chk("neg_outs",
          {n_hsync, n_vsync, n_ls, n_fs, n_x_en, n_y_en, n_win_en},
          e ^ 7'b1100000);
    end
    hs = h; vs = v; wr = w; addr = a; wdata = d;
    model(h, v, w, a, d);
  endtask

  task automatic line(input logic vs_too, input int wr_at,
                      input logic [1:0] a, input logic [11:0] d0,
                      input logic [11:0] d1, input int rst_at);
    lx_cnt = 0; lx_first = -1; ly_cnt = 0; lw_cnt = 0;
    for (int c = 0; c < LEN; c++) begin
      logic w;
      logic [1:0] aa;
      logic [11:0] dd;
      w  = (c == wr_at) || (c == wr_at + 1);
      aa = (c == wr_at + 1) ? a + 2'd1 : a;
      dd = (c == wr_at + 1) ? d1 : d0;
      step(c < 8, vs_too && c < 8, w, aa, dd);
      if (c >= 1) begin
        if (p_x_en) begin
          lx_cnt++;
          if (lx_first < 0) lx_first = c;
        end
        if (p_y_en) ly_cnt++;
        if (p_win_en) lw_cnt++;
      end
      if (c == rst_at) begin
        chk("pre_rst_x_en", p_x_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_x_en", p_x_en, 0);
        chk("rst_n_x_en", n_x_en, 0);
        chk("rst_win_en", p_win_en, 0);
        chk("rst_hsync", p_hsync, 0);
        chk("rst_n_hsync", n_hsync, 1);
        q.delete();
        model_reset();
        hs = 1'b0; vs = 1'b0; wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  task automatic line_chk(input string tag, input int xc, input int xf,
                          input int yc);
    chk({tag, "_xcnt"}, lx_cnt, xc);
    chk({tag, "_xfirst"}, lx_first, xf);
    chk({tag, "_ycnt"}, ly_cnt, yc);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_p_sync", {p_hsync, p_vsync}, 2'b00);
    chk("rst_n_sync", {n_hsync, n_vsync}, 2'b11);
    chk("rst_p_outs", {p_ls, p_fs, p_x_en, p_y_en, p_win_en}, 0);
    chk("rst_n_outs", {n_ls, n_fs, n_x_en, n_y_en, n_win_en}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (10) step(0, 0, 0, 0, 0);
    line(0, NW, 0, 0, 0, NR);
    line_chk("l0", 640, 1, 0);

    line(1, NW, 0, 0, 0, NR);
    line_chk("a0", 640, 1, 699);
    line(0, 20, 0, 259, 640, NR);
    line_chk("a1", 640, 1, 699);
    line(0, 20, 2, 2, 4, NR);
    line_chk("a2", 640, 1, 699);

    repeat (4) step(0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    line(0, 20, 0, 100, 100, NR);
    line_chk("b1", 381, 260, 0);
    line(0, NW, 0, 0, 0, NR);
    line_chk("b2", 381, 260, 699);
    chk("b2_win", lw_cnt, 381);
    line(0, NW, 0, 0, 0, NR);
    line_chk("b3", 381, 260, 699);
    line(0, NW, 0, 0, 0, NR);
    line_chk("b4", 381, 260, 0);

    line(1, 0, 2, 0, 4, NR);
    line_chk("c0", 0, -1, 0);
    line(0, 20, 0, 10, 500, NR);
    line_chk("c1", 0, -1, 0);
    line(0, NW, 0, 0, 0, NR);
    line_chk("c2", 0, -1, 699);
    chk("c2_win", lw_cnt, 0);

    line(1, NW, 0, 0, 0, 100);
    chk("d0_xcnt", lx_cnt, 90);
    chk("d0_xfirst", lx_first, 11);

    repeat (10) step(0, 0, 0, 0, 0);
    line(0, NW, 0, 0, 0, NR);
    line_chk("r1", 640, 1, 0);
    chk("r1_win", lw_cnt, 0);
    line(0, NW, 0, 0, 0, NR);
    line_chk("r2", 640, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
